matmul_tile_sched: RTL and testbench
====================================

# matmul_tile_sched

Top-level sequencer for one tiled matrix multiply on the systolic datapath. It loops over K weight tiles, and for each tile it:
- commands a weight-FIFO fill from weight memory,
- launches the compute controller,
- waits for the tile to drain into the accumulator.

It sits above the FIFO-in controller and compute controller and replaces bench-driven pulse sequencing. Optionally it prefetches the next weight tile while the current one computes.

## Interface
Parameters:
- DATA_WIDTH, 16, width of row-count fields
- ADDR_WIDTH, 8, weight/input memory address width
- SYS_ROW, 4, systolic rows; sets FIFO fill time
- TILE_W, 8, width of tile counter
- FILL_CYC, 2*SYS_ROW+2, cycles from fifo_in_en pulse until FIFO fill is complete

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin job; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE next cycle
- cfg_num_row  in  DATA_WIDTH  input rows per tile
- cfg_num_tiles  in  TILE_W  number of K tiles
- cfg_w_base  in  ADDR_WIDTH  weight address of tile 0
- cfg_w_stride  in  ADDR_WIDTH  weight address step per tile
- cfg_in_base  in  ADDR_WIDTH  input address of tile 0
- cfg_in_stride  in  ADDR_WIDTH  input address step per tile
- tile_done  in  1  one-cycle pulse: last psum row of current tile written
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pulse at job end
- accum_clr  out  1  one-cycle accumulator clear
- fifo_in_en  out  1  one-cycle FIFO fill command
- repeat_cnt  out  32  fill repeat count; constant 2
- w_base_addr  out  ADDR_WIDTH  weight address for current fill
- compute_en  out  1  one-cycle compute-controller start
- num_row_out  out  DATA_WIDTH  latched cfg_num_row
- in_base_addr  out  ADDR_WIDTH  input address for current tile
- weight_fill  out  1  qualifies compute_en; high only for tile 0
- weight_change  out  1  qualifies compute_en; high for every tile
- tile_idx  out  TILE_W  index of tile currently computing

## Operation
- All cfg_* inputs are latched on the accepted start; later changes are ignored until the next start.
- Address generation:
  - w_base_addr and in_base_addr are running accumulators: base + k*stride, modulo 2^ADDR_WIDTH (wrap silently).
- States: IDLE, CLR, FILL, FWAIT, LAUNCH, RUN, DONE.
- IDLE:
  - start=1 and cfg_num_tiles=0 -> DONE. No accum_clr, fill or compute pulses.
  - start=1 and cfg_num_tiles>0 -> CLR.
  - start while busy is ignored.
- CLR: accum_clr=1 for one cycle -> FILL.
- FILL: fifo_in_en=1 for one cycle, with w_base_addr for tile k -> FWAIT. The fill counter loads FILL_CYC.
- FWAIT: when the counter reaches 0 -> LAUNCH.
- LAUNCH:
  - compute_en=1 for one cycle; weight_fill=(k==0); weight_change=1.
  - num_row_out and in_base_addr are valid for tile k.
  - -> RUN.
- RUN: waits for tile_done. On tile_done:
  - k+1==cfg_num_tiles -> DONE.
  - otherwise k++, then -> FILL (serial build) or -> LAUNCH/FWAIT (prefetch build, see Configuration).
- DONE: done=1 for one cycle, busy drops -> IDLE.
- tile_done outside RUN is ignored.
- abort in any state -> IDLE next cycle. No done pulse. Pulses in flight are cancelled.
- Reset value of every output: 0, except repeat_cnt=2 (constant).
- Reset mid-operation: same outputs, IDLE, k=0.

## Timing
- start at edge t -> CLR at t+1, with accum_clr high during cycle t+1.
- fifo_in_en is high at t+2.
- compute_en is high at t+3+FILL_CYC. This assumes FWAIT spans FILL_CYC cycles and the cycle the counter reaches 0 enters LAUNCH.
- In serial mode, tile_done at cycle r gives fifo_in_en at r+1 and compute_en at r+2+FILL_CYC.
- done is high 1 cycle after the final tile_done.
- busy is low the cycle after done.
- At most one of accum_clr, fifo_in_en, compute_en is high in any cycle.

## Configuration
- TILE_SCHED_PREFETCH_EN defined:
  - On entering RUN for tile k with k+1<cfg_num_tiles, fifo_in_en for tile k+1 is issued on the first RUN cycle. The fill counter runs concurrently with compute.
  - On tile_done: if the counter is already 0 -> LAUNCH next cycle; else -> FWAIT to finish the count.
  - w_base_addr advances at the prefetch pulse. in_base_addr and tile_idx advance at LAUNCH.
- TILE_SCHED_PREFETCH_EN undefined: strictly serial as described in Operation. No fill overlaps RUN.

## Test plan
- Reset + idle:
  - Stimulus: assert rst mid-RUN.
  - Response: all outputs 0 the same cycle, repeat_cnt=2; after release, start works normally.
- Single tile, serial:
  - Stimulus: cfg_num_tiles=1, w_base=0x10, in_base=0x20, num_row=4; tile_done 20 cycles after compute_en.
  - Response: one accum_clr, one fifo_in_en with w_base_addr=0x10, compute_en at t+3+FILL_CYC with weight_fill=1, then done.
- Three tiles, serial, stride 8:
  - Response: w_base_addr 0x10/0x18/0x20 and in_base_addr 0x20/0x28/0x30; weight_fill high only on first compute_en; exactly 3 compute_en pulses, then done.
- Prefetch (TILE_SCHED_PREFETCH_EN):
  - Stimulus: 2 tiles, tile_done 30 cycles after compute_en.
  - Response: second fifo_in_en one cycle after first RUN entry; second compute_en exactly 1 cycle after first tile_done.
  - Variant: tile_done after 3 cycles. Response: second compute_en delayed until FILL_CYC has elapsed.
- Edge cases:
  - cfg_num_tiles=0 -> done 1 cycle after start, no other pulses.
  - Address wrap: w_base=0xF8, stride 8 -> 0xF8 then 0x00.
- Abort / spurious events:
  - Stimulus: abort during FWAIT of tile 1.
  - Response: IDLE next cycle, busy=0, no done; tile_done in IDLE ignored; start during busy ignored.

Source files
------------

// File: rtl/matmul_tile_sched_if.sv
// Control/config bundle between the tile scheduler and its driver.
// dbg_state mirrors the scheduler FSM state for observation.
interface matmul_tile_sched_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int TILE_W     = 8
);
   logic                  start;
   logic                  abort;
   logic [DATA_WIDTH-1:0] cfg_num_row;
   logic [TILE_W-1:0]     cfg_num_tiles;
   logic [ADDR_WIDTH-1:0] cfg_w_base;
   logic [ADDR_WIDTH-1:0] cfg_w_stride;
   logic [ADDR_WIDTH-1:0] cfg_in_base;
   logic [ADDR_WIDTH-1:0] cfg_in_stride;
   logic                  tile_done;
   logic                  busy;
   logic                  done;
   logic                  accum_clr;
   logic                  fifo_in_en;
   logic [31:0]           repeat_cnt;
   logic [ADDR_WIDTH-1:0] w_base_addr;
   logic                  compute_en;
   logic [DATA_WIDTH-1:0] num_row_out;
   logic [ADDR_WIDTH-1:0] in_base_addr;
   logic                  weight_fill;
   logic                  weight_change;
   logic [TILE_W-1:0]     tile_idx;
   logic [2:0]            dbg_state;

   // Strobes are one-cycle pulses; there is no backpressure on any of them.
   modport master (
      output start, abort, cfg_num_row, cfg_num_tiles, cfg_w_base, cfg_w_stride,
             cfg_in_base, cfg_in_stride, tile_done,
      input  busy, done, accum_clr, fifo_in_en, repeat_cnt, w_base_addr, compute_en,
             num_row_out, in_base_addr, weight_fill, weight_change, tile_idx, dbg_state
   );
   modport slave (
      input  start, abort, cfg_num_row, cfg_num_tiles, cfg_w_base, cfg_w_stride,
             cfg_in_base, cfg_in_stride, tile_done,
      output busy, done, accum_clr, fifo_in_en, repeat_cnt, w_base_addr, compute_en,
             num_row_out, in_base_addr, weight_fill, weight_change, tile_idx, dbg_state
   );
endinterface

// File: rtl/matmul_tile_sched.sv
// Sequences clear / weight fill / compute / drain over K weight tiles.
// Define TILE_SCHED_PREFETCH_EN to overlap the next tile's fill with compute.
module matmul_tile_sched #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 8,
   parameter int SYS_ROW    = 4,
   parameter int TILE_W     = 8,
   parameter int FILL_CYC   = 2*SYS_ROW+2
) (
   input logic                clk,
   input logic                rst,
   matmul_tile_sched_if.slave bus
);
   localparam int CNT_W = $clog2(FILL_CYC+1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FILL_CYC);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_FILL, S_FWAIT, S_LAUNCH, S_RUN, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [TILE_W-1:0]     tile_idx_q, tile_idx_d;
   logic [TILE_W-1:0]     num_tiles_q, num_tiles_d;
   logic [ADDR_WIDTH-1:0] w_base_q, w_base_d, in_base_q, in_base_d;
   logic [ADDR_WIDTH-1:0] w_stride_q, w_stride_d, in_stride_q, in_stride_d;
   logic [DATA_WIDTH-1:0] num_row_q, num_row_d;
`ifdef TILE_SCHED_PREFETCH_EN
   logic                  first_q, first_d;
   logic                  pf_q, pf_d;
`endif
   logic clr_pulse, fill_pulse, comp_pulse, wfill, wchange, done_pulse;
   logic last_tile;

   assign last_tile = (tile_idx_q + TILE_W'(1)) == num_tiles_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         tile_idx_q  <= '0;
         num_tiles_q <= '0;
         w_base_q    <= '0;
         in_base_q   <= '0;
         w_stride_q  <= '0;
         in_stride_q <= '0;
         num_row_q   <= '0;
`ifdef TILE_SCHED_PREFETCH_EN
         first_q     <= 1'b0;
         pf_q        <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tile_idx_q  <= tile_idx_d;
         num_tiles_q <= num_tiles_d;
         w_base_q    <= w_base_d;
         in_base_q   <= in_base_d;
         w_stride_q  <= w_stride_d;
         in_stride_q <= in_stride_d;
         num_row_q   <= num_row_d;
`ifdef TILE_SCHED_PREFETCH_EN
         first_q     <= first_d;
         pf_q        <= pf_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q != '0) ? cnt_q - CNT_ONE : cnt_q;
      tile_idx_d  = tile_idx_q;
      num_tiles_d = num_tiles_q;
      w_base_d    = w_base_q;
      in_base_d   = in_base_q;
      w_stride_d  = w_stride_q;
      in_stride_d = in_stride_q;
      num_row_d   = num_row_q;
`ifdef TILE_SCHED_PREFETCH_EN
      first_d     = 1'b0;
      pf_d        = pf_q;
`endif
      clr_pulse   = 1'b0;
      fill_pulse  = 1'b0;
      comp_pulse  = 1'b0;
      wfill       = 1'b0;
      wchange     = 1'b0;
      done_pulse  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               num_tiles_d = bus.cfg_num_tiles;
               w_base_d    = bus.cfg_w_base;
               w_stride_d  = bus.cfg_w_stride;
               in_base_d   = bus.cfg_in_base;
               in_stride_d = bus.cfg_in_stride;
               num_row_d   = bus.cfg_num_row;
               tile_idx_d  = '0;
`ifdef TILE_SCHED_PREFETCH_EN
               pf_d        = 1'b0;
`endif
               state_d = (bus.cfg_num_tiles == '0) ? S_DONE : S_CLR;
            end
         end
         S_CLR: begin
            clr_pulse = 1'b1;
            state_d   = S_FILL;
         end
         S_FILL: begin
            fill_pulse = 1'b1;
            cnt_d      = CNT_LOAD;
            state_d    = S_FWAIT;
         end
         S_FWAIT: begin
            if (cnt_q <= CNT_ONE) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            comp_pulse = 1'b1;
            wfill      = (tile_idx_q == '0);
            wchange    = 1'b1;
            state_d    = S_RUN;
`ifdef TILE_SCHED_PREFETCH_EN
            first_d = 1'b1;
            // w_base_addr moves to tile k+1 so the first RUN cycle can fill it.
            if (!last_tile) begin
               pf_d     = 1'b1;
               w_base_d = w_base_q + w_stride_q;
            end
`endif
         end
         S_RUN: begin
`ifdef TILE_SCHED_PREFETCH_EN
            if (first_q && pf_q) begin
               fill_pulse = 1'b1;
               cnt_d      = CNT_LOAD;
            end
`endif
            if (bus.tile_done) begin
               if (last_tile) begin
                  state_d = S_DONE;
               end else begin
`ifdef TILE_SCHED_PREFETCH_EN
                  state_d = (!first_q && cnt_q <= CNT_ONE) ? S_LAUNCH : S_FWAIT;
`else
                  tile_idx_d = tile_idx_q + TILE_W'(1);
                  w_base_d   = w_base_q + w_stride_q;
                  in_base_d  = in_base_q + in_stride_q;
                  state_d    = S_FILL;
`endif
               end
            end
         end
         S_DONE: begin
            done_pulse = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
`ifdef TILE_SCHED_PREFETCH_EN
      // The prefetched tile becomes the computing tile as LAUNCH is entered.
      if (state_d == S_LAUNCH && pf_q) begin
         tile_idx_d = tile_idx_q + TILE_W'(1);
         in_base_d  = in_base_q + in_stride_q;
         pf_d       = 1'b0;
      end
`endif
      if (bus.abort) begin
         state_d    = S_IDLE;
         clr_pulse  = 1'b0;
         fill_pulse = 1'b0;
         comp_pulse = 1'b0;
         wfill      = 1'b0;
         wchange    = 1'b0;
         done_pulse = 1'b0;
`ifdef TILE_SCHED_PREFETCH_EN
         first_d    = 1'b0;
         pf_d       = 1'b0;
`endif
      end
   end

   assign bus.busy          = (state_q != S_IDLE);
   assign bus.done          = done_pulse;
   assign bus.accum_clr     = clr_pulse;
   assign bus.fifo_in_en    = fill_pulse;
   assign bus.repeat_cnt    = 32'd2;
   assign bus.w_base_addr   = w_base_q;
   assign bus.compute_en    = comp_pulse;
   assign bus.num_row_out   = num_row_q;
   assign bus.in_base_addr  = in_base_q;
   assign bus.weight_fill   = wfill;
   assign bus.weight_change = wchange;
   assign bus.tile_idx      = tile_idx_q;
   assign bus.dbg_state     = state_q;
endmodule

// File: tb/tb_matmul_tile_sched.sv
// Bench for matmul_tile_sched: schedules are predicted from the cycle rules and
// compared event-by-event against the observed strobe trace.
module tb_matmul_tile_sched;
   localparam int F = 10;
   localparam int W = 80;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   overlap = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] obs_q[$];

   matmul_tile_sched_if #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .TILE_W(8)) bus ();

   matmul_tile_sched #(
      .DATA_WIDTH(16), .ADDR_WIDTH(8), .SYS_ROW(4), .TILE_W(8), .FILL_CYC(F)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [W-1:0] mk(input int kind, input int c, input logic [15:0] rows,
                                        input logic [7:0] tile, input logic [7:0] inb,
                                        input logic [7:0] wb, input logic wf, input logic wc);
      return {8'(kind), 24'(c), rows, tile, inb, wb, wf, wc, 6'b0};
   endfunction

   // observed strobe trace
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.accum_clr)  obs_q.push_back(mk(1, cyc, 16'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0));
         if (bus.fifo_in_en) obs_q.push_back(mk(2, cyc, 16'h0, 8'h0, 8'h0, bus.w_base_addr, 1'b0, 1'b0));
         if (bus.compute_en) obs_q.push_back(mk(3, cyc, bus.num_row_out, bus.tile_idx,
                                                 bus.in_base_addr, 8'h0, bus.weight_fill,
                                                 bus.weight_change));
         if (bus.done)       obs_q.push_back(mk(4, cyc, 16'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0));
         if (int'(bus.accum_clr) + int'(bus.fifo_in_en) + int'(bus.compute_en) > 1) overlap++;
      end
   end

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input string pre);
      chk({pre, "_busy"},          W'(bus.busy), 0);
      chk({pre, "_done"},          W'(bus.done), 0);
      chk({pre, "_accum_clr"},     W'(bus.accum_clr), 0);
      chk({pre, "_fifo_in_en"},    W'(bus.fifo_in_en), 0);
      chk({pre, "_compute_en"},    W'(bus.compute_en), 0);
      chk({pre, "_w_base_addr"},   W'(bus.w_base_addr), 0);
      chk({pre, "_in_base_addr"},  W'(bus.in_base_addr), 0);
      chk({pre, "_num_row_out"},   W'(bus.num_row_out), 0);
      chk({pre, "_weight_fill"},   W'(bus.weight_fill), 0);
      chk({pre, "_weight_change"}, W'(bus.weight_change), 0);
      chk({pre, "_tile_idx"},      W'(bus.tile_idx), 0);
      chk({pre, "_repeat_cnt"},    W'(bus.repeat_cnt), 2);
   endtask

   task automatic drive_cfg_random();
      bus.cfg_num_row   = 16'($urandom);
      bus.cfg_num_tiles = 8'($urandom);
      bus.cfg_w_base    = 8'($urandom);
      bus.cfg_w_stride  = 8'($urandom);
      bus.cfg_in_base   = 8'($urandom);
      bus.cfg_in_stride = 8'($urandom);
   endtask

   // kill: 0 none, 1 abort during FWAIT of tile 1, 2 reset three cycles into tile 0 RUN
   task automatic run_job(input int n, input logic [7:0] wb, input logic [7:0] ws,
                          input logic [7:0] ib, input logic [7:0] in_stride,
                          input logic [15:0] rows, input int dmin, input int dmax,
                          input bit spur, input int kill);
      int fq[$];
      int cq[$];
      int rq[$];
      int t, f, c, r, done_c, kill_c, last, ri;
      logic [7:0] wa, ia;
      t = cyc;
      exp_q.delete();
      obs_q.delete();
      overlap = 0;
      for (int k = 0; k < n; k++) begin
         if (k == 0) begin
            f = t + 2;
            c = f + 1 + F;
         end else begin
`ifdef TILE_SCHED_PREFETCH_EN
            f = cq[k-1] + 1;
            c = (rq[k-1] + 1 > f + F + 1) ? rq[k-1] + 1 : f + F + 1;
`else
            f = rq[k-1] + 1;
            c = f + 1 + F;
`endif
         end
         r = c + int'($urandom_range(dmax, dmin));
         fq.push_back(f);
         cq.push_back(c);
         rq.push_back(r);
      end
      done_c = (n == 0) ? t + 1 : rq[n-1] + 1;
      kill_c = -1;
      if (kill == 1 && n > 1) kill_c = fq[1] + 2;
      if (kill == 2 && n > 0) kill_c = cq[0] + 3;
      if (n > 0 && (kill_c < 0 || t + 1 < kill_c))
         exp_q.push_back(mk(1, t + 1, 16'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0));
      for (int k = 0; k < n; k++) begin
         wa = wb + 8'(k) * ws;
         ia = ib + 8'(k) * in_stride;
         if (kill_c < 0 || fq[k] < kill_c)
            exp_q.push_back(mk(2, fq[k], 16'h0, 8'h0, 8'h0, wa, 1'b0, 1'b0));
         if (kill_c < 0 || cq[k] < kill_c)
            exp_q.push_back(mk(3, cq[k], rows, 8'(k), ia, 8'h0, k == 0, 1'b1));
      end
      if (kill_c < 0)
         exp_q.push_back(mk(4, done_c, 16'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b0));

      bus.start         = 1'b1;
      bus.cfg_num_tiles = 8'(n);
      bus.cfg_w_base    = wb;
      bus.cfg_w_stride  = ws;
      bus.cfg_in_base   = ib;
      bus.cfg_in_stride = in_stride;
      bus.cfg_num_row   = rows;
      last = (kill_c >= 0) ? kill_c + 8 : done_c + 3;
      ri = 0;
      for (int p = t + 1; p <= last; p++) begin
         @(posedge clk);
         #1;
         if (kill_c < 0 && p == done_c)     chk("busy_at_done", W'(bus.busy), 1);
         if (kill_c < 0 && p == done_c + 1) chk("busy_after_done", W'(bus.busy), 0);
         if (kill_c >= 0 && p == kill_c + 1) chk("busy_after_kill", W'(bus.busy), 0);
         if (kill_c >= 0 && p == kill_c + 6) chk("busy_idle_late", W'(bus.busy), 0);
         bus.start     = 1'b0;
         bus.abort     = 1'b0;
         bus.tile_done = 1'b0;
         drive_cfg_random();
         if (spur && n > 0 && p == t + 1) bus.tile_done = 1'b1;
         if (spur && n > 0 && p == t + 2) bus.start = 1'b1;
         if (ri < n && p == rq[ri]) begin
            if (kill_c < 0 || p < kill_c) bus.tile_done = 1'b1;
            ri++;
         end
         if (kill == 1 && p == kill_c) bus.abort = 1'b1;
         if (kill_c >= 0 && p == kill_c + 2) bus.tile_done = 1'b1;
         if (kill == 2 && p == kill_c) begin
            rst = 1'b1;
            #1;
            check_idle("rst_mid");
         end
         if (kill == 2 && p == kill_c + 2) rst = 1'b0;
      end
      bus.tile_done = 1'b0;
      chk("event_count", W'(obs_q.size()), W'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         chk($sformatf("event%0d", i), obs_q[i], exp_q[i]);
      chk("pulse_overlap", W'(overlap), 0);
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.tile_done = 1'b0;
      drive_cfg_random();
      #2 rst = 1'b1;
      #1 check_idle("reset");
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;

      // single tile
      run_job(1, 8'h10, 8'h08, 8'h20, 8'h08, 16'd4, 20, 20, 1'b0, 0);
      // three tiles, stride 8
      run_job(3, 8'h10, 8'h08, 8'h20, 8'h08, 16'd4, 20, 20, 1'b1, 0);
      // zero tiles
      run_job(0, 8'h33, 8'h01, 8'h44, 8'h01, 16'd7, 1, 1, 1'b0, 0);
      // address wrap
      run_job(2, 8'hF8, 8'h08, 8'hFC, 8'h08, 16'd9, 5, 5, 1'b0, 0);
      // long and short tile drains
      run_job(2, 8'h40, 8'h10, 8'h80, 8'h20, 16'd12, 30, 30, 1'b0, 0);
      run_job(2, 8'h40, 8'h10, 8'h80, 8'h20, 16'd12, 3, 3, 1'b0, 0);
      // abort during fill wait of tile 1, then tile_done in idle
      run_job(3, 8'h10, 8'h08, 8'h20, 8'h08, 16'd4, 6, 12, 1'b0, 1);
      // reset mid-RUN, then a normal job
      run_job(2, 8'h55, 8'h04, 8'h66, 8'h04, 16'd5, 10, 10, 1'b0, 2);
      run_job(2, 8'h10, 8'h08, 8'h20, 8'h08, 16'd4, 4, 8, 1'b0, 0);
      // randomized jobs
      for (int j = 0; j < 8; j++)
         run_job(int'($urandom_range(4, 0)), 8'($urandom), 8'($urandom), 8'($urandom),
                 8'($urandom), 16'($urandom), 1, 15, 1'($urandom), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
